// File: rtl/fet_vec_pkg.sv
// Shared types and sizing helpers for the FET/net vector sequencer.
package fet_vec_pkg;

    typedef enum logic [1:0] {
        DIG_0 = 2'd0,
        DIG_1 = 2'd1,
        DIG_Z = 2'd2
    } digit_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int unsigned pow3(input int unsigned n);
        int unsigned r;
        r = 1;
        for (int unsigned i = 0; i < n; i++) begin
            r = r * 3;
        end
        return r;
    endfunction

    function automatic int unsigned idxWidth(input int unsigned numCh);
        return $clog2(pow3(numCh));
    endfunction

endpackage

// File: rtl/fet_vector_sequencer_counter.sv
// Base-3 counter, one digit per channel, with a binary mirror of its value.
module tri_digit_counter
    import fet_vec_pkg::*;
#(
    parameter int unsigned NUM_CH = 3
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              clear,
    input  logic                              inc,
    output logic [NUM_CH-1:0][1:0]            digits,
    output logic [idxWidth(NUM_CH)-1:0]       idx,
    output logic                              isLast
);

    localparam int unsigned IDX_W = idxWidth(NUM_CH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(pow3(NUM_CH) - 1);

    logic [NUM_CH-1:0][1:0] digitsNext;
    logic                   carry;

    always_comb begin
        digitsNext = digits;
        carry      = 1'b1;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (carry) begin
                if (digits[i] == DIG_Z) begin
                    digitsNext[i] = DIG_0;
                end else begin
                    digitsNext[i] = digits[i] + 2'd1;
                    carry         = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            digits <= '0;
            idx    <= '0;
        end else if (inc) begin
            digits <= digitsNext;
            idx    <= idx + IDX_W'(1);
        end
    end

    always_comb begin
        isLast = (idx == LAST_IDX);
    end

endmodule

// File: rtl/fet_vector_sequencer.sv
// Sweeps every 0/1/z combination over NUM_CH channels under a start/busy/done
// handshake, optionally skipping vectors with contention on shared nets.
module fet_vector_sequencer
    import fet_vec_pkg::*;
#(
    parameter int unsigned       NUM_CH      = 3,
    parameter int unsigned       HOLD        = 1,
    parameter logic [NUM_CH-1:0] SHARED_MASK = '0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        stop,
    input  logic                        skip_en,
    output logic [NUM_CH-1:0]           ch,
    output logic [NUM_CH-1:0]           drv_en,
    output logic                        vec_valid,
    output logic                        vec_strobe,
    output logic [idxWidth(NUM_CH)-1:0] vec_idx,
    output logic                        busy,
    output logic                        done
);

    localparam int unsigned IDX_W  = idxWidth(NUM_CH);
    localparam int unsigned HOLD_W = (HOLD > 1) ? $clog2(HOLD) : 1;

    state_t                 state, stateNext;
    logic                   skipLatched;
    logic [HOLD_W-1:0]      holdCnt, holdNext;
    logic [NUM_CH-1:0][1:0] digits;
    logic [IDX_W-1:0]       idx;
    logic                   isLast;
    logic                   counterInc, counterClear;

    logic [NUM_CH-1:0] drvMask, valMask, chVal;
    logic              contention, holdDone;

    logic [NUM_CH-1:0] drvNext, valNext;
    logic              validNext, strobeNext, busyNext, doneNext;
    logic [IDX_W-1:0]  idxNext;

    tri_digit_counter #(
        .NUM_CH(NUM_CH)
    ) uCounter (
        .clk   (clk),
        .rst   (rst),
        .clear (counterClear),
        .inc   (counterInc),
        .digits(digits),
        .idx   (idx),
        .isLast(isLast)
    );

    always_comb begin
        drvMask = '0;
        valMask = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            drvMask[i] = (digits[i] != DIG_Z);
            valMask[i] = (digits[i] == DIG_1);
        end
        contention = skipLatched && ($countones(drvMask & SHARED_MASK) >= 2);
        // An illegal vector occupies a single cycle regardless of HOLD.
        holdDone   = contention || (holdCnt == HOLD_W'(HOLD - 1));
    end

    always_comb begin
        stateNext    = state;
        holdNext     = holdCnt;
        counterInc   = 1'b0;
        counterClear = 1'b0;
        case (state)
            IDLE: begin
                counterClear = 1'b1;
                holdNext     = '0;
                if (start) stateNext = RUN;
            end
            RUN: begin
                if (stop) begin
                    stateNext = IDLE;
                    holdNext  = '0;
                end else if (holdDone) begin
                    holdNext = '0;
                    if (isLast) stateNext = DONE;
                    else        counterInc = 1'b1;
                end else begin
                    holdNext = holdCnt + HOLD_W'(1);
                end
            end
            DONE: begin
                counterClear = 1'b1;
                holdNext     = '0;
                stateNext    = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            holdCnt     <= '0;
            skipLatched <= 1'b0;
        end else begin
            state   <= stateNext;
            holdCnt <= holdNext;
            if (state == IDLE && start) skipLatched <= skip_en;
        end
    end

    always_comb begin
        drvNext    = '0;
        valNext    = '0;
        validNext  = 1'b0;
        strobeNext = 1'b0;
        idxNext    = '0;
        busyNext   = 1'b0;
        doneNext   = (state == DONE);
        if (state == RUN) begin
            busyNext = 1'b1;
            idxNext  = idx;
            if (!contention) begin
                drvNext    = drvMask;
                valNext    = valMask;
                validNext  = 1'b1;
                strobeNext = (holdCnt == '0);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            drv_en     <= '0;
            chVal      <= '0;
            vec_valid  <= 1'b0;
            vec_strobe <= 1'b0;
            vec_idx    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            drv_en     <= drvNext;
            chVal      <= valNext;
            vec_valid  <= validNext;
            vec_strobe <= strobeNext;
            vec_idx    <= idxNext;
            busy       <= busyNext;
            done       <= doneNext;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : gCh
        assign ch[i] = drv_en[i] ? chVal[i] : 1'bz;
    end

endmodule

// File: tb/tb_fet_vector_sequencer.sv
// Three sequencer configurations on shared stimulus, checked every cycle
// against a queue-based sweep model plus literal expectations.
module tb_fet_vector_sequencer;

    typedef struct packed {
        logic        valid;
        logic        strobe;
        logic        busy;
        logic        done;
        logic [15:0] idx;
        logic [7:0]  drv;
        logic [7:0]  val;
    } rec_t;

    logic clk, rst, start, stop, skipEn;

    wire  [2:0] chA, chB;
    wire  [1:0] chC;
    logic [2:0] drvA, drvB;
    logic [1:0] drvC;
    logic [4:0] idxA, idxB;
    logic [3:0] idxC;
    logic validA, strobeA, busyA, doneA;
    logic validB, strobeB, busyB, doneB;
    logic validC, strobeC, busyC, doneC;

    fet_vector_sequencer #(.NUM_CH(3), .HOLD(1), .SHARED_MASK(3'b000)) dutA (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .skip_en(skipEn),
        .ch(chA), .drv_en(drvA), .vec_valid(validA), .vec_strobe(strobeA),
        .vec_idx(idxA), .busy(busyA), .done(doneA));

    fet_vector_sequencer #(.NUM_CH(3), .HOLD(1), .SHARED_MASK(3'b110)) dutB (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .skip_en(skipEn),
        .ch(chB), .drv_en(drvB), .vec_valid(validB), .vec_strobe(strobeB),
        .vec_idx(idxB), .busy(busyB), .done(doneB));

    fet_vector_sequencer #(.NUM_CH(2), .HOLD(3), .SHARED_MASK(2'b00)) dutC (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .skip_en(skipEn),
        .ch(chC), .drv_en(drvC), .vec_valid(validC), .vec_strobe(strobeC),
        .vec_idx(idxC), .busy(busyC), .done(doneC));

    int nCh[3]   = '{3, 3, 2};
    int holdN[3] = '{1, 1, 3};
    int maskN[3] = '{0, 6, 0};

    rec_t q[3][$];
    rec_t expR[3];
    rec_t act[3];
    int   cyc = 0;
    int   startCyc[3];
    bit   checkOn = 0;
    bit   skipPhase = 0;

    int nChecks = 0;
    int nFail   = 0;

    int strobes[3], valids[3], skips[3], doneCnt[3], firstDone[3], lastDone[3], firstIdx[3];
    logic [7:0] cap5Drv, cap5Val;

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] a, input logic [31:0] e);
        nChecks++;
        if (a !== e) begin
            nFail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, a, e, $time);
        end
    endtask

    // Expected per-cycle outputs of a full sweep, derived arithmetically from the index.
    task automatic pushSweep(input int d, input bit skip);
        int   n;
        rec_t r;
        n = 1;
        for (int i = 0; i < nCh[d]; i++) n = n * 3;
        for (int v = 0; v < n; v++) begin
            int rem, dig, shared;
            logic [7:0] drv, val;
            rem = v; drv = '0; val = '0;
            for (int c = 0; c < nCh[d]; c++) begin
                dig = rem % 3;
                rem = rem / 3;
                if (dig != 2) drv[c] = 1'b1;
                if (dig == 1) val[c] = 1'b1;
            end
            shared = 0;
            for (int c = 0; c < 8; c++) if (drv[c] && maskN[d][c]) shared++;
            if (skip && shared >= 2) begin
                r = '0; r.busy = 1'b1; r.idx = 16'(v);
                q[d].push_back(r);
            end else begin
                for (int h = 0; h < holdN[d]; h++) begin
                    r = '0; r.busy = 1'b1; r.valid = 1'b1; r.strobe = (h == 0);
                    r.idx = 16'(v); r.drv = drv; r.val = val;
                    q[d].push_back(r);
                end
            end
        end
        r = '0; r.done = 1'b1;
        q[d].push_back(r);
    endtask

    always @(posedge clk) begin
        cyc++;
        for (int d = 0; d < 3; d++) begin
            if (rst) begin
                q[d].delete();
                expR[d] = '0;
            end else begin
                bit wasEmpty;
                wasEmpty = (q[d].size() == 0);
                expR[d]  = wasEmpty ? rec_t'('0) : q[d].pop_front();
                if (expR[d].busy && stop) begin
                    q[d].delete();
                end else if (wasEmpty && start) begin
                    pushSweep(d, skipEn);
                    startCyc[d] = cyc;
                end
            end
        end
    end

    always_comb begin
        act[0] = '{validA, strobeA, busyA, doneA, {11'b0, idxA}, {5'b0, drvA}, {5'b0, chA & drvA}};
        act[1] = '{validB, strobeB, busyB, doneB, {11'b0, idxB}, {5'b0, drvB}, {5'b0, chB & drvB}};
        act[2] = '{validC, strobeC, busyC, doneC, {12'b0, idxC}, {6'b0, drvC}, {6'b0, chC & drvC}};
    end

    always @(negedge clk) begin
        if (checkOn) begin
            for (int d = 0; d < 3; d++) begin
                chk($sformatf("d%0d_drv_en", d),     act[d].drv,    expR[d].drv);
                chk($sformatf("d%0d_ch", d),         act[d].val,    expR[d].val);
                chk($sformatf("d%0d_vec_valid", d),  act[d].valid,  expR[d].valid);
                chk($sformatf("d%0d_vec_strobe", d), act[d].strobe, expR[d].strobe);
                chk($sformatf("d%0d_vec_idx", d),    act[d].idx,    expR[d].idx);
                chk($sformatf("d%0d_busy", d),       act[d].busy,   expR[d].busy);
                chk($sformatf("d%0d_done", d),       act[d].done,   expR[d].done);
                if (act[d].strobe) begin
                    strobes[d]++;
                    if (firstIdx[d] < 0) firstIdx[d] = int'(act[d].idx);
                end
                if (act[d].valid) valids[d]++;
                if (act[d].busy && !act[d].valid) skips[d]++;
                if (act[d].done) begin
                    doneCnt[d]++;
                    if (doneCnt[d] == 1) firstDone[d] = cyc;
                    lastDone[d] = cyc;
                end
            end
            if (act[0].valid && act[0].idx == 16'd5) begin
                cap5Drv = act[0].drv;
                cap5Val = act[0].val;
            end
            if (skipPhase) chk("B_no_contention", 32'($countones(act[1].drv & 8'h06) >= 2), 0);
        end
    end

    task automatic clearStats();
        for (int d = 0; d < 3; d++) begin
            strobes[d] = 0; valids[d] = 0; skips[d] = 0; doneCnt[d] = 0;
            firstDone[d] = -1; lastDone[d] = -1; firstIdx[d] = -1;
        end
        cap5Drv = 8'hff;
        cap5Val = 8'hff;
    endtask

    task automatic pulseStart();
        @(negedge clk); start = 1;
        @(negedge clk); start = 0;
    endtask

    task automatic waitIdxA(input int target);
        int n;
        n = 0;
        while (!(validA && idxA == 5'(target)) && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("reach_idx%0d", target), 32'(n < 60), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1; start = 0; stop = 0; skipEn = 0;
        clearStats();
        @(posedge clk);
        @(negedge clk);
        checkOn = 1;
        repeat (2) @(negedge clk);
        chk("rst_busy", busyA, 0);
        chk("rst_valid", validA, 0);
        chk("rst_drv_en", drvA, 0);
        chk("rst_done", doneA, 0);
        rst = 0;
        repeat (2) @(negedge clk);

        // Plain sweep, no filter.
        clearStats();
        pulseStart();
        repeat (40) @(negedge clk);
        chk("p1_A_strobes", strobes[0], 27);
        chk("p1_A_done_latency", firstDone[0] - startCyc[0], 28);
        chk("p1_A_dones", doneCnt[0], 1);
        chk("p1_A_idx5_drv_en", cap5Drv, 8'b110);
        chk("p1_A_idx5_ch", cap5Val, 8'b010);
        chk("p1_B_strobes", strobes[1], 27);
        chk("p1_C_strobes", strobes[2], 9);
        chk("p1_C_valid_cycles", valids[2], 27);
        chk("p1_C_done_latency", firstDone[2] - startCyc[2], 28);

        // Contention filter on.
        clearStats();
        skipEn = 1; skipPhase = 1;
        pulseStart();
        skipEn = 0;
        repeat (40) @(negedge clk);
        skipPhase = 0;
        chk("p2_B_valid", valids[1], 15);
        chk("p2_B_skips", skips[1], 12);
        chk("p2_B_done_latency", firstDone[1] - startCyc[1], 28);
        chk("p2_A_strobes", strobes[0], 27);

        // Stop mid-sweep, then a fresh start.
        clearStats();
        pulseStart();
        waitIdxA(10);
        stop = 1;
        @(negedge clk); stop = 0;
        repeat (40) @(negedge clk);
        chk("p3_A_no_done_after_stop", doneCnt[0], 0);
        chk("p3_C_no_done_after_stop", doneCnt[2], 0);
        clearStats();
        pulseStart();
        repeat (3) @(negedge clk);
        start = 1;
        @(negedge clk); start = 0;
        waitIdxA(7);
        chk("p4_A_restart_idx", firstIdx[0], 0);
        rst = 1;
        @(negedge clk); rst = 0;
        chk("p4_rst_busy", busyA, 0);
        chk("p4_rst_valid", validA, 0);
        chk("p4_rst_idx", idxA, 0);
        repeat (40) @(negedge clk);
        chk("p4_A_no_done_after_rst", doneCnt[0], 0);

        // Start held high: back-to-back sweeps with one IDLE cycle between.
        clearStats();
        skipEn = 1; skipPhase = 1;
        @(negedge clk); start = 1;
        repeat (40) @(negedge clk);
        start = 0;
        repeat (45) @(negedge clk);
        skipPhase = 0;
        skipEn = 0;
        chk("p5_A_dones", doneCnt[0], 2);
        chk("p5_A_done_gap", lastDone[0] - firstDone[0], 29);
        chk("p5_B_dones", doneCnt[1], 2);
        chk("p5_B_valid", valids[1], 30);
        chk("p5_C_done_gap", lastDone[2] - firstDone[2], 29);

        checkOn = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
